// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants and receiver state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;

  localparam logic [7:0] KEY_ARRIBA = 8'h75;
  localparam logic [7:0] KEY_ABAJO  = 8'h72;
  localparam logic [7:0] KEY_IZQ    = 8'h6B;
  localparam logic [7:0] KEY_DER    = 8'h74;
  localparam logic [7:0] KEY_SUBIR  = 8'h73;
  localparam logic [7:0] KEY_SEL    = 8'h6C;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/ps2_receptor_teclado_filtro.sv
// Synchronizes ps2_clk/ps2_data and debounces the clock; fall pulses one cycle
// when the filtered clock drops (2 sync + FILT samples of latency, no backpressure).
module ps2_filtro #(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CW = $clog2(FILT + 1);

  logic          clk_m;
  logic          clk_s;
  logic          dat_m;
  logic          clk_f;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      dat_m  <= 1'b1;
      data_s <= 1'b1;
      clk_f  <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      clk_m  <= ps2_clk;
      clk_s  <= clk_m;
      dat_m  <= ps2_data;
      data_s <= dat_m;
      fall   <= 1'b0;
      // cnt counts consecutive samples disagreeing with the filtered level
      if (clk_s == clk_f) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        clk_f <= clk_s;
        cnt   <= '0;
        fall  <= clk_f;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receptor_teclado.sv
// PS/2 device-to-host frame receiver: decodes scan codes, folds F0/E0 prefixes into flags.
// Outputs update the cycle after the stop-bit fall; no backpressure, frames cannot be stalled.
module ps2_receptor_teclado
  import ps2_pkg::*;
#(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 100000,
  parameter int TW      = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] Cambio,
  output logic       got_data,
  output logic       break_flag,
  output logic       ext_flag,
  output logic       frame_err
);

  logic fall;
  logic data_s;

  ps2_filtro #(.FILT(FILT)) u_filtro (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    sh, sh_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          byte_ok;
  logic          err;
  logic          pend_break;
  logic          pend_ext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      par     <= 1'b0;
      tmo     <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      par     <= par_n;
      tmo     <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    par_n     = par;
    tmo_n     = tmo;
    byte_ok   = 1'b0;
    err       = 1'b0;
    if (state != IDLE && tmo == TW'(TIMEOUT)) begin
      state_n = IDLE;
      tmo_n   = '0;
      err     = 1'b1;
    end else begin
      tmo_n = (state == IDLE || fall) ? '0 : tmo + 1'b1;
      if (fall) begin
        case (state)
          IDLE: begin
            // rx_en only gates the start of a frame, never aborts one in progress
            if (rx_en) begin
              if (!data_s) begin
                state_n   = DATA;
                bit_cnt_n = '0;
              end else begin
                err = 1'b1;
              end
            end
          end
          DATA: begin
            sh_n[bit_cnt] = data_s;
            bit_cnt_n     = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state_n = PARITY;
          end
          PARITY: begin
            par_n   = data_s;
            state_n = STOP;
          end
          STOP: begin
            state_n = IDLE;
            if (data_s && (^{sh, par})) byte_ok = 1'b1;
            else                        err     = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      Cambio     <= '0;
      got_data   <= 1'b0;
      break_flag <= 1'b0;
      ext_flag   <= 1'b0;
      frame_err  <= 1'b0;
      pend_break <= 1'b0;
      pend_ext   <= 1'b0;
    end else begin
      got_data  <= 1'b0;
      frame_err <= err;
      if (err) begin
        pend_break <= 1'b0;
        pend_ext   <= 1'b0;
      end else if (byte_ok) begin
        if (sh == PS2_BREAK) begin
          pend_break <= 1'b1;
        end else if (sh == PS2_EXT) begin
          pend_ext <= 1'b1;
        end else begin
          Cambio     <= sh;
          break_flag <= pend_break;
          ext_flag   <= pend_ext;
          got_data   <= 1'b1;
          pend_break <= 1'b0;
          pend_ext   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/ps2_receptor_teclado.md
Name: ps2_receptor_teclado

Overview:
Receives PS/2 keyboard frames (device-to-host) on ps2_clk/ps2_data and decodes them into scan codes. It produces the byte/strobe pair (Cambio, got_data) consumed by the time-setting counters, with break (F0) and extended (E0) prefixes resolved into flags. It sits between the board PS/2 pins and all keyboard-driven control logic.

Parameters:
FILT, 8, consecutive equal samples required before filtered ps2_clk changes level
TIMEOUT, 100000, clk cycles without a filtered falling edge mid-frame before the frame is aborted
TW, 17, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-low reset (rst=0 resets on the clk edge)
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
rx_en  in  1  1 = accept new frames; 0 = ignore start bits while in IDLE
Cambio  out  8  last valid non-prefix scan code; held until the next one
got_data  out  1  one-cycle strobe: Cambio/break_flag/ext_flag updated this cycle
break_flag  out  1  Cambio was preceded by F0 (key release)
ext_flag  out  1  Cambio was preceded by E0 (extended key)
frame_err  out  1  one-cycle strobe on start/parity/stop error or timeout

Behaviour:
- Reset (rst=0): Cambio=0, got_data=0, break_flag=0, ext_flag=0, frame_err=0, FSM=IDLE, pending prefixes cleared, filter outputs=1, counters=0.
- ps2_clk and ps2_data each pass through a 2-FF synchronizer. Filtered clock takes a new level only after FILT consecutive identical synchronized samples. fall = filtered clock 1->0, one-cycle pulse. Data is sampled from the synchronized ps2_data on the fall cycle.
- Frame: start(0), 8 data LSB first, odd parity, stop(1). One bit per fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  IDLE: on fall with rx_en=1: data=0 -> DATA with bit count=0; data=1 -> frame_err pulse, stay IDLE. fall with rx_en=0 is ignored.
  DATA: shift bit in at position count; after 8th bit -> PARITY.
  PARITY: store bit -> STOP.
  STOP: on fall check stop=1 and XOR(8 data bits, parity)=1; both true -> byte valid; otherwise frame_err pulse. Always -> IDLE.
- Byte valid handling, outputs registered the cycle after the stop-bit fall:
  byte=F0 -> pend_break=1, no strobe. byte=E0 -> pend_ext=1, no strobe.
  otherwise -> Cambio=byte, break_flag=pend_break, ext_flag=pend_ext, got_data=1 for exactly one cycle, both pendings cleared.
- Frame error or timeout clears both pendings; Cambio and flags keep their previous values.
- Timeout: in DATA/PARITY/STOP, a counter increments each clk and resets on fall. When it reaches TIMEOUT -> IDLE, frame_err pulse, counter=0. The counter is held at 0 in IDLE.
- Deasserting rx_en mid-frame does not abort the frame; it only gates the next start bit.
- got_data and frame_err are never asserted in the same cycle.
- Reset asserted mid-frame: immediate return to reset state; the partial frame is lost with no strobe.

Decomposition:
- Package ps2_pkg: constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, key codes KEY_ARRIBA=8'h75, KEY_ABAJO=8'h72, KEY_IZQ=8'h6B, KEY_DER=8'h74, KEY_SUBIR=8'h73, KEY_SEL=8'h6C; rx state enumeration.
- Sub-module ps2_filtro: synchronizers, glitch filter, falling-edge pulse; outputs fall and data_s. The top level holds the FSM, shift register, prefix logic and timeout.

Test Plan:
- Frame 0x73 (parity 0), PS/2 period 80 us -> got_data one cycle, Cambio=0x73, break_flag=0, ext_flag=0, frame_err never asserted.
- Frames F0 then 0x72 -> single got_data only after 0x72: Cambio=0x72, break_flag=1; a following 0x6C gives break_flag=0.
- Frames E0, F0, 0x75 -> Cambio=0x75, ext_flag=1, break_flag=1; exactly one strobe.
- 0x73 with parity flipped to 1 -> frame_err one cycle, no got_data, Cambio keeps prior value (0x6C); a following E0 + bad frame leaves ext pending cleared.
- 4 bits sent, then ps2_clk held high for TIMEOUT+10 cycles -> frame_err; then a full 0x6C frame -> Cambio=0x6C, got_data.
- 3-cycle low glitches on ps2_clk during IDLE and mid-frame -> no state change; rst=0 pulsed at bit 5 of a frame -> all outputs 0, no strobe, next frame 0x73 decoded correctly.
